// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath mux
// selects, ALU operations and condition codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_check.sv
// NZCV flags register and combinational condition evaluation against the
// stored flags; C/V are only refreshed by arithmetic operations.
module cond_check
  import multicycle_control_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       flag_wr,
  input  logic       cv_wr,
  output logic       CondEx
);

  logic [3:0] flags_q;
  logic       n, z, c, v;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      flags_q <= 4'b0000;
    end else if (flag_wr) begin
      flags_q[3:2] <= ALUFlags[3:2];
      if (cv_wr) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign {n, z, c, v} = flags_q;

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle ARM-subset datapath, plus
// instruction decode; predication comes from cond_check.
//
//   state  | meaning
//   FETCH  | read instr at PC, IR <= mem, PC <= PC+4
//   DECODE | read register file, PC+8 on ALU result
//   MEMADR | compute load/store address
//   MEMRD  | read data memory
//   MEMWB  | write load data to Rd (or PC)
//   MEMWR  | write store data to memory
//   EXECR  | DP with register operand
//   EXECI  | DP with immediate operand
//   ALUWB  | write ALU result to Rd (or PC)
//   BRANCH | PC <= PC+8 + offset
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  logic       cond_ex, flag_wr, cv_wr, rd_pc;
  logic       is_cmp, dp_valid;
  logic [1:0] dp_alu;
  logic       pcw_c, rw_c, mw_c, irw_c;

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_valid = 1'b1;
    is_cmp   = 1'b0;
    case (Funct[4:1])
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b1010: begin dp_alu = ALU_SUB; is_cmp = 1'b1; end
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      default: dp_valid = 1'b0;
    endcase
  end

  assign rd_pc   = (Rd == 4'hF);
  assign flag_wr = ((state_q == S_EXECR) || (state_q == S_EXECI)) && cond_ex && (Funct[0] || is_cmp);
  assign cv_wr   = ~dp_alu[1];

  cond_check u_cond_check (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .flag_wr  (flag_wr),
    .cv_wr    (cv_wr),
    .CondEx   (cond_ex)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: case (Op)
                  2'b01:   state_d = S_MEMADR;
                  2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                  2'b10:   state_d = S_BRANCH;
                  default: state_d = S_FETCH;
                endcase
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcw_c = 1'b0; rw_c = 1'b0; mw_c = 1'b0; irw_c = 1'b0;
    AdrSrc = 1'b0; ALUSrcA = 1'b0; ALUSrcB = SRCB_RD2; ResultSrc = RES_ALUOUT;
    ImmSrc = IMM_DP; RegSrc = 2'b00; ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        irw_c = 1'b1; pcw_c = 1'b1; ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
        if (Op == 2'b10)                     RegSrc = 2'b01;
        else if (Op == 2'b01 && !Funct[0])   RegSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM; ImmSrc = IMM_MEM;
        ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        rw_c  = cond_ex & ~rd_pc;
        pcw_c = cond_ex & rd_pc;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; RegSrc = 2'b10; mw_c = cond_ex;
      end
      S_EXECR: ALUControl = dp_alu;
      S_EXECI: begin
        ALUSrcB = SRCB_IMM; ImmSrc = IMM_DP; ALUControl = dp_alu;
      end
      S_ALUWB: begin
        rw_c  = cond_ex & ~is_cmp & dp_valid & ~rd_pc;
        pcw_c = cond_ex & ~is_cmp & rd_pc;
      end
      S_BRANCH: begin
        RegSrc = 2'b01; ALUSrcB = SRCB_IMM; ImmSrc = IMM_BR;
        ResultSrc = RES_ALURES; pcw_c = cond_ex;
      end
      default: ;
    endcase
  end

  // Reset holds state at FETCH, whose enables are active; gate them off
  // so nothing is written while RESETn is low.
  assign PCWrite  = pcw_c & RESETn;
  assign RegWrite = rw_c  & RESETn;
  assign MemWrite = mw_c  & RESETn;
  assign IRWrite  = irw_c & RESETn;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: per-cycle expected
// output vectors are queued per instruction and compared as the FSM steps.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] State;

  multicycle_control dut (
    .CLK(CLK), .RESETn(RESETn), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct { string tag; logic [19:0] v; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  wire [19:0] outs = {State, PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
                      ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};
  localparam logic [19:0] EN_MASK = 20'h0F000;

  // Expected output vector: fixed per-state fields plus the caller-supplied
  // ALU op, RegSrc and predicated write enables.
  function automatic logic [19:0] ex(state_e st, logic [1:0] aluc, logic [1:0] rs,
                                     logic pcw, logic rw, logic mw);
    logic irw = 1'b0, adr = 1'b0, srca = 1'b0;
    logic [1:0] srcb = 2'b00, ress = 2'b00, imm = 2'b00;
    case (st)
      S_FETCH:  begin irw = 1'b1; srca = 1'b1; srcb = 2'b10; ress = 2'b10; end
      S_DECODE: begin srca = 1'b1; srcb = 2'b10; ress = 2'b10; end
      S_MEMADR: begin srcb = 2'b01; imm = 2'b01; end
      S_MEMRD:  adr = 1'b1;
      S_MEMWB:  ress = 2'b01;
      S_MEMWR:  adr = 1'b1;
      S_EXECI:  srcb = 2'b01;
      S_BRANCH: begin srcb = 2'b01; imm = 2'b10; ress = 2'b10; end
      default: ;
    endcase
    return {st, pcw, rw, mw, irw, adr, srca, srcb, ress, imm, rs, aluc};
  endfunction

  task automatic cmp(input string tag, input logic [19:0] exp_v);
    logic [19:0] obs;
    obs = outs;
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cmp_flags(input string tag, input logic [3:0] exp_f);
    logic [3:0] obs;
    obs = dut.u_cond_check.flags_q;
    checks++;
    assert (obs === exp_f) else begin
      errors++;
      $error("FAIL %s: observed flags %b expected %b", tag, obs, exp_f);
    end
  endtask

  task automatic push(input string tag, input logic [19:0] v);
    exp_t e;
    e.tag = tag; e.v = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      #1;
      cmp(e.tag, e.v);
      @(negedge CLK);
    end
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] fl);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = fl;
  endtask

  task automatic push_fd(input string tag, input logic [1:0] rs);
    push({tag, ".fetch"}, ex(S_FETCH, ALU_ADD, 2'b00, 1'b1, 1'b0, 1'b0));
    push({tag, ".decode"}, ex(S_DECODE, ALU_ADD, rs, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic dp(input string tag, input logic [3:0] c, input logic [5:0] f,
                    input logic [3:0] r, input logic [3:0] fl, input logic [1:0] aluc,
                    input logic pcw, input logic rw);
    set_instr(c, 2'b00, f, r, fl);
    push_fd(tag, 2'b00);
    push({tag, ".exec"}, ex(f[5] ? S_EXECI : S_EXECR, aluc, 2'b00, 1'b0, 1'b0, 1'b0));
    push({tag, ".aluwb"}, ex(S_ALUWB, ALU_ADD, 2'b00, pcw, rw, 1'b0));
    drain();
  endtask

  task automatic br(input string tag, input logic [3:0] c, input logic pcw);
    set_instr(c, 2'b10, 6'b000000, 4'd0, 4'b0000);
    push_fd(tag, 2'b01);
    push({tag, ".branch"}, ex(S_BRANCH, ALU_ADD, 2'b01, pcw, 1'b0, 1'b0));
    drain();
  endtask

  task automatic strne(input string tag, input logic mw);
    set_instr(COND_NE, 2'b01, 6'b010000, 4'd2, 4'b0000);
    push_fd(tag, 2'b10);
    push({tag, ".memadr"}, ex(S_MEMADR, ALU_SUB, 2'b00, 1'b0, 1'b0, 1'b0));
    push({tag, ".memwr"}, ex(S_MEMWR, ALU_ADD, 2'b10, 1'b0, 1'b0, mw));
    drain();
  endtask

  initial begin
    RESETn = 1'b0;
    set_instr(4'h0, 2'b00, 6'b000000, 4'd0, 4'b0000);
    #2;
    cmp("reset_outputs", ex(S_FETCH, ALU_ADD, 2'b00, 1'b1, 1'b0, 1'b0) & ~EN_MASK);
    cmp_flags("reset_flags", 4'b0000);
    @(negedge CLK);
    RESETn = 1'b1;

    dp("adds_r1", COND_AL, 6'b101001, 4'd1, 4'b0100, ALU_ADD, 1'b0, 1'b1);
    cmp_flags("adds_flags", 4'b0100);

    dp("cmp_z1", COND_AL, 6'b010101, 4'd0, 4'b0110, ALU_SUB, 1'b0, 1'b0);
    cmp_flags("cmp_z1_flags", 4'b0110);
    br("beq_taken", COND_EQ, 1'b1);
    dp("cmp_z0", COND_AL, 6'b010101, 4'd0, 4'b0000, ALU_SUB, 1'b0, 1'b0);
    cmp_flags("cmp_z0_flags", 4'b0000);
    br("beq_not_taken", COND_EQ, 1'b0);

    set_instr(COND_AL, 2'b01, 6'b011001, 4'd15, 4'b0000);
    push_fd("ldr_pc", 2'b00);
    push("ldr_pc.memadr", ex(S_MEMADR, ALU_ADD, 2'b00, 1'b0, 1'b0, 1'b0));
    push("ldr_pc.memrd", ex(S_MEMRD, ALU_ADD, 2'b00, 1'b0, 1'b0, 1'b0));
    push("ldr_pc.memwb", ex(S_MEMWB, ALU_ADD, 2'b00, 1'b1, 1'b0, 1'b0));
    drain();

    dp("cmp_set_z", COND_AL, 6'b010101, 4'd0, 4'b0100, ALU_SUB, 1'b0, 1'b0);
    strne("strne_z1", 1'b0);
    dp("cmp_clr_z", COND_AL, 6'b010101, 4'd0, 4'b0000, ALU_SUB, 1'b0, 1'b0);
    strne("strne_z0", 1'b1);

    set_instr(COND_AL, 2'b11, 6'b000000, 4'd0, 4'b0000);
    push_fd("undef_op", 2'b00);
    drain();

    dp("orr_r3", COND_AL, 6'b111000, 4'd3, 4'b1111, ALU_ORR, 1'b0, 1'b1);
    cmp_flags("orr_nos_flags", 4'b0000);
    dp("cmp_set_cv", COND_AL, 6'b010101, 4'd0, 4'b0011, ALU_SUB, 1'b0, 1'b0);
    dp("ands_r4", COND_AL, 6'b100001, 4'd4, 4'b1100, ALU_AND, 1'b0, 1'b1);
    cmp_flags("ands_keeps_cv", 4'b1111);
    dp("undef_dp", COND_AL, 6'b100110, 4'd5, 4'b0000, ALU_ADD, 1'b0, 1'b0);
    dp("adds_nv", 4'b1111, 6'b101001, 4'd1, 4'b0000, ALU_ADD, 1'b0, 1'b0);
    cmp_flags("nv_flags_kept", 4'b1111);
    dp("add_ge", COND_GE, 6'b101000, 4'd6, 4'b0000, ALU_ADD, 1'b0, 1'b1);
    dp("add_lt", COND_LT, 6'b101000, 4'd6, 4'b0000, ALU_ADD, 1'b0, 1'b0);
    dp("add_pc", COND_AL, 6'b101000, 4'd15, 4'b0000, ALU_ADD, 1'b1, 1'b0);

    set_instr(COND_AL, 2'b00, 6'b101000, 4'd1, 4'b0000);
    push_fd("rst_mid", 2'b00);
    push("rst_mid.exec", ex(S_EXECI, ALU_ADD, 2'b00, 1'b0, 1'b0, 1'b0));
    drain();
    #1;
    cmp("rst_mid.aluwb", ex(S_ALUWB, ALU_ADD, 2'b00, 1'b0, 1'b1, 1'b0));
    RESETn = 1'b0;
    #1;
    cmp("rst_mid.forced", ex(S_FETCH, ALU_ADD, 2'b00, 1'b1, 1'b0, 1'b0) & ~EN_MASK);
    cmp_flags("rst_mid_flags", 4'b0000);
    @(negedge CLK);
    RESETn = 1'b1;

    br("b_after_reset", COND_AL, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and one asynchronous active-low reset, with all ports as listed in REQ-002..REQ-006.
REQ-002 Ports: CLK in 1 (rising-edge clock); RESETn in 1 (asynchronous, active-low reset).
REQ-003 Ports: Cond in 4 (Instr[31:28]); Op in 2 (Instr[27:26]); Funct in 6 (Instr[25:20]); Rd in 4 (Instr[15:12]); ALUFlags in 4 (NZCV from ALU, combinational).
REQ-004 Ports: PCWrite, RegWrite, MemWrite, IRWrite out 1 (write enables); AdrSrc out 1 (0=PC, 1=ALUOut); ALUSrcA out 1 (0=RD1 reg, 1=PC).
REQ-005 Ports: ALUSrcB out 2 (00=RD2, 01=ExtImm, 10=const 4); ResultSrc out 2 (00=ALUOut, 01=ReadData, 10=ALUResult).
REQ-006 Ports: ImmSrc out 2 (00=imm8 DP, 01=imm12 mem, 10=imm24 branch, sign-extended <<2); RegSrc out 2 (bit0=read R15 for RA1, bit1=read Rd for RA2); ALUControl out 2 (00 ADD, 01 SUB, 10 AND, 11 ORR); State out 4 (debug).

Function
REQ-007 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH; unlisted outputs are 0.
REQ-008 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1; next DECODE.
REQ-009 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, RegSrc per Op (Op=10 -> 01; Op=01 and Funct[0]=0 -> 10; else 00).
REQ-010 DECODE next: Op=01 -> MEMADR; Op=00, Funct[5]=0 -> EXECR; Op=00, Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (undefined op, no side effect).
REQ-011 MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl=ADD if Funct[3]=1 else SUB; next MEMRD if Funct[0]=1 else MEMWR.
REQ-012 MEMRD: AdrSrc=1; next MEMWB.
REQ-013 MEMWB: ResultSrc=01, RegWrite=CondEx and Rd!=15, PCWrite=CondEx and Rd=15; next FETCH.
REQ-014 MEMWR: AdrSrc=1, RegSrc=10, MemWrite=CondEx; next FETCH.
REQ-015 EXECR: ALUSrcA=0, ALUSrcB=00; EXECI: ALUSrcA=0, ALUSrcB=01, ImmSrc=00; both next ALUWB.
REQ-016 DP ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 1010 CMP (SUB), 0000 AND, 1100 ORR; other codes -> ADD with RegWrite suppressed.
REQ-017 ALUWB: ResultSrc=00, RegWrite=CondEx and not CMP and Rd!=15, PCWrite=CondEx and not CMP and Rd=15; next FETCH.
REQ-018 Flags register NZCV SHALL latch ALUFlags at the EXECR/EXECI clock edge iff CondEx and (Funct[0]=1 or CMP); C and V SHALL update only for ADD/SUB/CMP.
REQ-019 BRANCH: ALUSrcA=0, RegSrc=01, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx; next FETCH.
REQ-020 CondEx SHALL be combinational from Cond and the stored flags (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL); Cond=1111 SHALL evaluate false.
REQ-021 Latency: DP 4 cycles, LDR 5, STR 4, B 3 (FETCH to FETCH).

Reset
REQ-022 While RESETn=0: state=FETCH, flags=0000, and PCWrite/RegWrite/MemWrite/IRWrite forced 0 (asynchronously, any state).
REQ-023 First rising CLK edge after RESETn deasserts SHALL perform FETCH; reset mid-instruction SHALL abandon it with no further writes.

Structure
REQ-024 Shared package SHALL hold: state encoding, ALUControl, ImmSrc, ResultSrc and ALUSrcB constants, and condition codes.
REQ-025 Condition evaluation plus flags register SHALL be one sub-module, cond_check; the FSM plus decode remains in multicycle_control.

Verification
REQ-026 Reset: RESETn=0 in ALUWB -> PCWrite=RegWrite=MemWrite=0 immediately; State=FETCH.
REQ-027 ADDS R1 (Cond=1110, Op=00, Funct=101001, Rd=1), ALUFlags=0100 -> states FETCH,DECODE,EXECI,ALUWB; RegWrite=1 in ALUWB; flags=0100.
REQ-028 CMP then BEQ (Cond=0000, Op=10) with Z=1 -> BRANCH with ImmSrc=10, PCWrite=1; with Z=0 -> PCWrite=0 in BRANCH.
REQ-029 LDR R15 (Op=01, Funct=011001, Rd=15) -> 5 cycles; MEMWB has PCWrite=1 and RegWrite=0.
REQ-030 STRNE (Cond=0001) with Z=1 -> MEMWR with MemWrite=0; same with Z=0 -> MemWrite=1, AdrSrc=1.
REQ-031 Op=11 -> DECODE returns to FETCH; no enable asserted other than FETCH's.
